// File: rtl/count_bcd_converter.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module      : count_bcd_converter                                       |
// | Description : Sequential double-dabble binary-to-BCD converter with a   |
// |               leading-zero mask for the VGA digit renderer.             |
// | Revision    : 1.0 - initial release                                     |
// +-------------------------------------------------------------------------+
module count_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      count,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic [DIGITS*4-1:0]   bcd,
    output logic [DIGITS-1:0]     lz_mask,
    output logic                  out_valid
);

    localparam int                   c_BCD_W     = DIGITS * 4;
    localparam int                   c_CNT_W     = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_LOAD  = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [DIGITS-1:0]    c_LZ_RESET  = ~DIGITS'(1);
    localparam longint unsigned      c_DEC_RANGE = 64'd10 ** DIGITS;
    localparam longint unsigned      c_BIN_RANGE = 64'd1 << WIDTH;

    // Refuse to build a converter whose digits cannot hold every input value.
    generate
        if ((c_DEC_RANGE < c_BIN_RANGE) || (WIDTH < 2)) begin : g_param_check_fail
            $error("count_bcd_converter: DIGITS too small for WIDTH, or WIDTH < 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [WIDTH-1:0]       r_shift;
    logic [c_BCD_W-1:0]     r_scratch;
    logic [c_CNT_W-1:0]     r_bitcnt;
    logic [c_BCD_W-1:0]     r_bcd;
    logic [DIGITS-1:0]      r_lz_mask;
    logic                   r_out_valid;

    logic                   w_idle;
    logic                   w_accept;
    logic                   w_last;
    logic [c_BCD_W-1:0]     w_adj;
    logic [c_BCD_W-1:0]     w_scratch_nxt;
    logic [DIGITS-1:0]      w_lz_nxt;
    logic                   w_unused_adj_msb;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && in_valid;
    assign w_last   = (r_bitcnt == c_CNT_ONE);

    // Add-3 correction on every digit >= 5 before the shift; cannot overflow 4 bits.
    always_comb begin
        w_adj = r_scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_scratch[d*4 +: 4] >= 4'd5) begin
                w_adj[d*4 +: 4] = r_scratch[d*4 +: 4] + 4'd3;
            end
        end
    end

    // The adjusted MSB is always zero for legal parameters, so dropping it is safe.
    assign w_scratch_nxt    = {w_adj[c_BCD_W-2:0], r_shift[WIDTH-1]};
    assign w_unused_adj_msb = w_adj[c_BCD_W-1];

    // Digit i is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic zero_run;
        w_lz_nxt = '0;
        zero_run = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            zero_run    = zero_run & (w_scratch_nxt[d*4 +: 4] == 4'd0);
            w_lz_nxt[d] = zero_run;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_scratch   <= '0;
            r_bitcnt    <= '0;
            r_bcd       <= '0;
            r_lz_mask   <= c_LZ_RESET;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (w_accept) begin
                        r_shift   <= count;
                        r_scratch <= '0;
                        r_bitcnt  <= c_CNT_LOAD;
                    end
                end
                S_SHIFT: begin
                    r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                    r_scratch <= w_scratch_nxt;
                    r_bitcnt  <= r_bitcnt - c_CNT_ONE;
                    if (w_last) begin
                        r_bcd       <= w_scratch_nxt;
                        r_lz_mask   <= w_lz_nxt;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_idle;
    assign busy      = !w_idle;
    assign bcd       = r_bcd;
    assign lz_mask   = r_lz_mask;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_count_bcd_converter.sv
`default_nettype none
// Directed and randomized self-checking bench for count_bcd_converter,
// with a decimal reference model built from plain division.
module tb_count_bcd_converter;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [WIDTH-1:0]   count;
    logic               in_valid;
    logic               in_ready;
    logic               busy;
    logic [DIGITS*4-1:0] bcd;
    logic [DIGITS-1:0]  lz_mask;
    logic               out_valid;

    logic               auto_mode;
    logic [WIDTH-1:0]   count_drv;
    logic               in_valid_drv;
    logic [WIDTH-1:0]   ctr;
    logic [WIDTH-1:0]   ctr_seed;
    logic               ctr_load;

    int total = 0;
    int bad   = 0;

    count_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .count     (count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .busy      (busy),
        .bcd       (bcd),
        .lz_mask   (lz_mask),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Free-running switch-gated counter (switch held at 1).
    always @(posedge clk) begin
        if (ctr_load) ctr <= ctr_seed;
        else          ctr <= ctr + 16'd1;
    end

    assign count    = auto_mode ? ctr : count_drv;
    assign in_valid = auto_mode ? in_ready : in_valid_drv;

    function automatic logic [DIGITS*4-1:0] ref_bcd(input int unsigned v);
        logic [DIGITS*4-1:0] r;
        int unsigned t;
        t = v;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] ref_lz(input int unsigned v);
        logic [DIGITS-1:0] r;
        int unsigned t;
        int ndig;
        ndig = 1;
        t = v / 10;
        while (t > 0) begin
            ndig++;
            t = t / 10;
        end
        r = '0;
        for (int i = 1; i < DIGITS; i++) r[i] = (i >= ndig);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic convert(input logic [WIDTH-1:0] v, input string tag);
        int n;
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        count_drv    = v;
        in_valid_drv = 1'b1;
        step();
        in_valid_drv = 1'b0;
        count_drv    = 16'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd16);
        check({tag, "_bcd"}, 32'(bcd), 32'(ref_bcd(32'(v))));
        check({tag, "_lz"}, 32'(lz_mask), 32'(ref_lz(32'(v))));
        check({tag, "_busy_last"}, 32'(busy), 32'd1);
        step();
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_again"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int acc_k[$];
        int res_k[$];
        logic [DIGITS*4-1:0] res_b[$];
        logic [DIGITS-1:0]   res_l[$];
        logic [WIDTH-1:0]    exp_q[$];
        logic [WIDTH-1:0]    v;
        logic                pre_ready;
        logic [WIDTH-1:0]    pre_cnt;
        int                  n_ov;
        int                  done;
        int                  cycles;
        logic [WIDTH-1:0]    corners[8];

        auto_mode    = 1'b0;
        rst          = 1'b0;
        count_drv    = '0;
        in_valid_drv = 1'b0;
        ctr_seed     = '0;
        ctr_load     = 1'b1;

        #2 rst = 1'b1;
        #1;
        check("por_bcd", 32'(bcd), 32'h0);
        check("por_lz", 32'(lz_mask), 32'h1e);
        check("por_ov", 32'(out_valid), 32'd0);
        check("por_ready", 32'(in_ready), 32'd1);
        check("por_busy", 32'(busy), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        convert(16'd0, "zero");
        convert(16'd65535, "max");
        convert(16'd1234, "v1234");
        convert(16'd10, "v10");

        // Back-to-back with in_valid held; count changes right after acceptance.
        count_drv    = 16'd9;
        in_valid_drv = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            pre_ready = in_ready;
            step();
            if (pre_ready && in_valid_drv) acc_k.push_back(k);
            if (k == 0) count_drv = 16'd777;
            if (out_valid) begin
                res_k.push_back(k);
                res_b.push_back(bcd);
                res_l.push_back(lz_mask);
            end
            if (acc_k.size() == 2) in_valid_drv = 1'b0;
        end
        check("b2b_nacc", 32'(acc_k.size()), 32'd2);
        check("b2b_nres", 32'(res_k.size()), 32'd2);
        if (acc_k.size() == 2 && res_k.size() == 2) begin
            check("b2b_acc0", 32'(acc_k[0]), 32'd0);
            check("b2b_acc1", 32'(acc_k[1]), 32'd18);
            check("b2b_res0_k", 32'(res_k[0]), 32'd16);
            check("b2b_res0_bcd", 32'(res_b[0]), 32'h00009);
            check("b2b_res1_k", 32'(res_k[1]), 32'd34);
            check("b2b_res1_bcd", 32'(res_b[1]), 32'h00777);
            check("b2b_res1_lz", 32'(res_l[1]), 32'h18);
        end

        // Abort a conversion mid-flight with an asynchronous reset.
        count_drv    = 16'd4321;
        in_valid_drv = 1'b1;
        step();
        in_valid_drv = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("abort_busy_pre", 32'(busy), 32'd1);
        check("abort_bcd_pre", 32'(bcd), 32'h00777);
        rst = 1'b1;
        #1;
        check("abort_bcd", 32'(bcd), 32'h0);
        check("abort_lz", 32'(lz_mask), 32'h1e);
        check("abort_ov", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        n_ov = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid) n_ov++;
        end
        check("abort_no_ov", 32'(n_ov), 32'd0);
        convert(16'd4321, "v4321");

        corners = '{16'd9, 16'd99, 16'd100, 16'd999, 16'd1000, 16'd9999, 16'd10000, 16'd59999};
        foreach (corners[i]) convert(corners[i], "corner");
        for (int i = 0; i < 12; i++) begin
            v = 16'($urandom_range(0, 65535));
            convert(v, "rand");
        end

        // Counter-driven stream: in_valid tied to in_ready.
        ctr_seed = 16'($urandom);
        ctr_load = 1'b1;
        step();
        ctr_load  = 1'b0;
        auto_mode = 1'b1;
        done      = 0;
        cycles    = 0;
        while (done < 200 && cycles < 200 * 18 + 100) begin
            pre_ready = in_ready;
            pre_cnt   = ctr;
            step();
            cycles++;
            if (pre_ready) exp_q.push_back(pre_cnt);
            if (out_valid) begin
                check("auto_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    v = exp_q.pop_front();
                    check("auto_bcd", 32'(bcd), 32'(ref_bcd(32'(v))));
                    check("auto_lz", 32'(lz_mask), 32'(ref_lz(32'(v))));
                end
                done++;
            end
        end
        auto_mode = 1'b0;
        check("auto_count", 32'(done), 32'd200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_bcd_converter.md
Name: count_bcd_converter

Overview:
- Downstream consumer of the 16-bit switch-gated `Counter` in the VGA display path.
- Converts the binary `count` value into packed BCD digits with a sequential double-dabble engine, one bit per clock.
- Also produces a leading-zero mask so the VGA digit renderer can blank unused digits.
- Uses a valid/ready input handshake and emits a one-cycle result strobe.

Parameters:
- WIDTH, 16, width of the binary input; matches the counter output.
- DIGITS, 5, number of BCD digits produced. Elaboration must fail if 10**DIGITS < 2**WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- count  input  WIDTH  binary value to convert.
- in_valid  input  1  request to convert `count`.
- in_ready  output  1  high when the block can accept a request.
- busy  output  1  high while a conversion is in progress.
- bcd  output  DIGITS*4  packed BCD result; digit 0 (units) in bits [3:0].
- lz_mask  output  DIGITS  bit i high means digit i is a leading zero. Bit 0 is always 0.
- out_valid  output  1  one-cycle strobe: `bcd` and `lz_mask` updated this cycle.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; bcd=0; lz_mask={DIGITS-1{1},0} (5'b11110 at default); out_valid=0; busy=0; in_ready=1; internal shift and scratch registers cleared. Any in-flight conversion is discarded with no out_valid.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). busy = (state!=IDLE). Both are decoded from the state register; no combinational path from in_valid.
- IDLE:
  - On an edge with in_valid && in_ready: latch `count` into the shift register, clear the BCD scratch, load bit counter = WIDTH, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per clock:
  - First, add 3 to every scratch digit >= 5, all digits in parallel.
  - Then shift {scratch, shift_reg} left by 1.
  - Decrement the bit counter.
  - On the edge performing iteration WIDTH: load `bcd` from the final scratch, load `lz_mask`, set out_valid=1, go to DONE.
- DONE: lasts exactly one cycle with out_valid=1. Next edge: out_valid=0, go to IDLE.
- Latency: acceptance at edge E0 -> out_valid high in the cycle following edge E(WIDTH), which is E16 at default. in_ready is high again after E(WIDTH+1).
- Throughput: with in_valid held high, one conversion per WIDTH+2 cycles; the next acceptance occurs at E(WIDTH+2).
- in_valid while busy: ignored. No queueing and no latching of `count`. Changes to `count` after acceptance do not affect the result.
- `bcd` and `lz_mask` hold their last result between strobes. They change only on the out_valid-asserting edge or on reset.
- lz_mask computation: bit i (i>=1) = 1 iff digits DIGITS-1..i are all zero. Bit 0 is always 0, so the value 0 displays as a single "0".
- Arithmetic: digit adjust is 4-bit add-3 with no carry out; the >=5 test guarantees no overflow. The scratch never exceeds DIGITS*4 bits for legal parameters.

Test Plan:
- Reset: rst=1 mid-sim -> bcd=20'h00000, lz_mask=5'b11110, out_valid=0, in_ready=1, busy=0 immediately, without waiting for a clock edge.
- count=16'd0, single in_valid pulse -> busy for 17 cycles; out_valid pulse 16 cycles after acceptance; bcd=20'h00000, lz_mask=5'b11110.
- count=16'd65535 -> bcd=20'h65535, lz_mask=5'b00000; count=16'd1234 -> bcd=20'h01234, lz_mask=5'b10000; count=16'd10 -> bcd=20'h00010, lz_mask=5'b11100.
- Accept count=16'd9, then switch count to 16'd777 with in_valid high throughout -> first result bcd=20'h00009. Second acceptance exactly 18 cycles after the first, with result bcd=20'h00777, lz_mask=5'b11000. No request is accepted while busy=1.
- Start conversion of 16'd4321, assert rst for 1 cycle during SHIFT iteration 8 -> no out_valid; outputs show reset values. A fresh request then yields bcd=20'h04321, lz_mask=5'b10000.
- Drive count directly from a `Counter` instance (switch=1), in_valid=in_ready -> each out_valid result equals the BCD of the count value sampled at its acceptance edge. Compare against a reference model over 200 conversions.
